// File: rtl/clk_divider_multi_pkg.sv
// Shared constants for the multi-channel clock divider, independent of count width.
package clk_divider_multi_pkg;

   localparam int unsigned MIN_PERIOD   = 2;
   localparam int unsigned MIN_HIGH     = 1;
   localparam int unsigned MAX_CHANNELS = 16;

endpackage : clk_divider_multi_pkg

// File: rtl/clk_divider_multi_channel.sv
// One divided-clock channel: period counter, shadow/active configuration and
// registered clock output. Shadow values only reach the active set at a period boundary.
module clk_div_channel
   import clk_divider_multi_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int DEFAULT_DIV  = 4,
   parameter int DEFAULT_HIGH = 2
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             enable_i,
   input  logic             load_i,
   input  logic             sync_i,
   input  logic [WIDTH-1:0] div_i,
   input  logic [WIDTH-1:0] high_i,
   output logic             clock_o,
   output logic [WIDTH-1:0] count_o,
   output logic             pending_o,
   output logic             tick_o,
   output logic             cfgErr_o
);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] activeDiv_q, activeDiv_d;
   logic [WIDTH-1:0] activeHigh_q, activeHigh_d;
   logic [WIDTH-1:0] shadowDiv_q, shadowDiv_d;
   logic [WIDTH-1:0] shadowHigh_q, shadowHigh_d;
   logic             pending_q, pending_d;
   logic             clkOut_q, clkOut_d;
   logic             tick_q, tick_d;
   logic             cfgErr_q, cfgErr_d;
   logic             atWrap;
   logic             cfgValid;
   logic             applyShadow;

   assign atWrap   = (count_q == activeDiv_q - WIDTH'(1));
   assign cfgValid = (div_i >= WIDTH'(MIN_PERIOD)) &&
                     (high_i >= WIDTH'(MIN_HIGH)) &&
                     (high_i < div_i);

   // A load in the same cycle as a wrap or sync lands in the shadow after the
   // old shadow has been applied, so it stays pending for the next boundary.
   always_comb begin
      count_d      = count_q;
      activeDiv_d  = activeDiv_q;
      activeHigh_d = activeHigh_q;
      shadowDiv_d  = shadowDiv_q;
      shadowHigh_d = shadowHigh_q;
      pending_d    = pending_q;
      tick_d       = 1'b0;
      cfgErr_d     = 1'b0;
      applyShadow  = 1'b0;

      if (sync_i) begin
         count_d     = '0;
         tick_d      = 1'b1;
         applyShadow = pending_q;
      end else if (enable_i) begin
         if (atWrap) begin
            count_d     = '0;
            tick_d      = 1'b1;
            applyShadow = pending_q;
         end else begin
            count_d = count_q + WIDTH'(1);
         end
      end

      if (applyShadow) begin
         activeDiv_d  = shadowDiv_q;
         activeHigh_d = shadowHigh_q;
         pending_d    = 1'b0;
      end

      if (load_i) begin
         if (cfgValid) begin
            shadowDiv_d  = div_i;
            shadowHigh_d = high_i;
            pending_d    = 1'b1;
         end else begin
            cfgErr_d = 1'b1;
         end
      end

      clkOut_d = (count_d < activeHigh_d);
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         count_q      <= '0;
         activeDiv_q  <= WIDTH'(DEFAULT_DIV);
         activeHigh_q <= WIDTH'(DEFAULT_HIGH);
         shadowDiv_q  <= WIDTH'(DEFAULT_DIV);
         shadowHigh_q <= WIDTH'(DEFAULT_HIGH);
         pending_q    <= 1'b0;
         clkOut_q     <= 1'b1;
         tick_q       <= 1'b0;
         cfgErr_q     <= 1'b0;
      end else begin
         count_q      <= count_d;
         activeDiv_q  <= activeDiv_d;
         activeHigh_q <= activeHigh_d;
         shadowDiv_q  <= shadowDiv_d;
         shadowHigh_q <= shadowHigh_d;
         pending_q    <= pending_d;
         clkOut_q     <= clkOut_d;
         tick_q       <= tick_d;
         cfgErr_q     <= cfgErr_d;
      end
   end

   assign clock_o   = clkOut_q;
   assign count_o   = count_q;
   assign pending_o = pending_q;
   assign tick_o    = tick_q;
   assign cfgErr_o  = cfgErr_q;

endmodule : clk_div_channel

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: shared controls fan out to
// independent channels whose outputs are packed into flat buses.
module clk_divider_multi
   import clk_divider_multi_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int WIDTH        = 32,
   parameter int DEFAULT_DIV  = 4,
   parameter int DEFAULT_HIGH = 2
) (
   input  logic                    clock_in,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [NUM_CH-1:0]       load,
   input  logic [WIDTH-1:0]        div_in,
   input  logic [WIDTH-1:0]        high_in,
   input  logic                    sync,
   output logic [NUM_CH-1:0]       clock_out,
   output logic [NUM_CH*WIDTH-1:0] n_clks,
   output logic [NUM_CH-1:0]       pending,
   output logic [NUM_CH-1:0]       period_tick,
   output logic [NUM_CH-1:0]       cfg_err
);

   if (NUM_CH < 1 || NUM_CH > int'(MAX_CHANNELS)) begin : g_badNumCh
      $error("clk_divider_multi: NUM_CH out of range");
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_channel
      clk_div_channel #(
         .WIDTH        (WIDTH),
         .DEFAULT_DIV  (DEFAULT_DIV),
         .DEFAULT_HIGH (DEFAULT_HIGH)
      ) u_channel (
         .clock_in  (clock_in),
         .reset     (reset),
         .enable_i  (enable),
         .load_i    (load[ch]),
         .sync_i    (sync),
         .div_i     (div_in),
         .high_i    (high_in),
         .clock_o   (clock_out[ch]),
         .count_o   (n_clks[ch*WIDTH +: WIDTH]),
         .pending_o (pending[ch]),
         .tick_o    (period_tick[ch]),
         .cfgErr_o  (cfg_err[ch])
      );
   end

endmodule : clk_divider_multi
